rect_fill_engine: RTL
=====================

Name: rect_fill_engine

Overview:
- Parametrised drawing engine that sits between a command source and the framebuffer write port of the VGA controller.
- Generalises the fixed draw block. It accepts a rectangle command (two corners, colour, mode) over a valid/ready handshake.
- Emits one pixel write per accepted beat (X, Y, R, G, B) with wr_valid/wr_ready backpressure, in either filled or outline mode.
- Runs in the pixel clock domain.

Parameters:
- XW, 8, coordinate width for X.
- YW, 8, coordinate width for Y.
- CW, 3, bits per colour channel.
- SCR_W, 160, visible framebuffer width in pixels. Used only when clipping is compiled in.
- SCR_H, 120, visible framebuffer height in pixels. Used only when clipping is compiled in.

Ports:
- CLK  in  1  pixel clock
- NRST  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x0, cmd_x1  in  XW  corner X coordinates, any order
- cmd_y0, cmd_y1  in  YW  corner Y coordinates, any order
- cmd_mode  in  1  0 = filled, 1 = outline only
- cmd_r, cmd_g, cmd_b  in  CW  colour
- X  out  XW  write X
- Y  out  YW  write Y
- R, G, B  out  CW  write colour
- wr_valid  out  1  pixel write valid
- wr_ready  in  1  framebuffer accepts the pixel
- busy  out  1  command in progress (not IDLE)
- done  out  1  one-cycle pulse when a command completes
- pix_count  out  XW+YW  pixels emitted by the current or last command

Behaviour:
- One clock (CLK); reset asynchronous, active-low (NRST).
- Reset values: state IDLE; cmd_ready=1; all other outputs 0, including X, Y, R, G, B, pix_count.
- FSM states are IDLE, SETUP, DRAW, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, the engine latches corners, mode and colour, clears pix_count, and moves to SETUP.
  - cmd_ready is 0 in every other state.
- SETUP (1 cycle):
  - xmin=min(x0,x1), xmax=max(x0,x1); same for Y.
  - Loads X=xmin, Y=ymin and the colour outputs, then moves to DRAW.
- DRAW:
  - wr_valid=1. X, Y, R, G and B are held stable while wr_valid && !wr_ready.
  - Each beat with wr_valid&&wr_ready: pix_count+=1, then the engine advances in raster order.
  - Filled mode: if X<xmax, X++; else X=xmin, Y++.
  - Outline mode, top row (Y==ymin) and bottom row (Y==ymax): same stepping as filled mode.
  - Outline mode, interior rows: X jumps xmin→xmax, then wraps to xmin, Y++.
  - If xmin==xmax in outline mode, each row emits a single pixel.
  - The beat at (xmax, ymax) is the last beat. It moves the FSM to DONE and wr_valid drops the next cycle.
- DONE (1 cycle): done=1, then return to IDLE. pix_count holds until the next command is accepted.
- Boundaries:
  - Degenerate command (x0==x1, y0==y1) emits exactly one pixel.
  - A single row or column emits xmax−xmin+1 or ymax−ymin+1 pixels, identical in both modes.
  - Coordinate counters never wrap past xmax or ymax.
  - No command is accepted while busy; cmd_valid is simply left pending.
- Reset mid-operation aborts the command immediately. No done pulse is produced and all outputs return to their reset values.
- Pixel counts: filled mode emits (W·H) pixels. Outline mode emits 2W+2(H−2) pixels for H≥2 and W≥2, where W=xmax−xmin+1 and H=ymax−ymin+1.

Optional Feature:
- Macro: RECT_CLIP_EN.
- Defined: in SETUP, xmax and ymax are clamped to SCR_W−1 and SCR_H−1.
  - If xmin≥SCR_W or ymin≥SCR_H, the engine goes SETUP→DONE directly with pix_count=0 and emits no pixels.
  - In outline mode, the clamped edges are drawn as the outline edges.
- Undefined: no clamping. Every coordinate is passed through; the framebuffer ignores out-of-range addresses.

Test Plan:
- Filled (3,4)-(4,5), colour 5/2/7, wr_ready=1:
  - Writes (3,4),(4,4),(3,5),(4,5) on consecutive cycles with R=5, G=2, B=7.
  - done pulses the cycle after the last beat; pix_count=4.
- Same rectangle with corners given as (4,5)-(3,5)... i.e. swapped, (4,5)-(3,4): identical write sequence and pix_count=4.
- Outline (0,0)-(3,2): writes (0,0),(1,0),(2,0),(3,0),(0,1),(3,1),(0,2),(1,2),(2,2),(3,2); pix_count=10.
- Backpressure, filled (0,0)-(1,0):
  - Hold wr_ready=0 for 3 cycles on the first beat; X=0, Y=0 stay stable with wr_valid=1.
  - After release, (1,0) is written, then done; pix_count=2.
- Reset: assert NRST=0 after 2 beats of filled (0,0)-(7,7).
  - All outputs are 0 immediately and no done pulse occurs.
  - After release, cmd_ready=1 and a new command runs normally.
- RECT_CLIP_EN defined:
  - Filled (150,100)-(170,130) emits X 150..159, Y 100..119; pix_count=200.
  - Filled (200,0)-(210,5) emits zero beats, done pulses, pix_count=0.

Source files
------------

// File: rtl/rect_fill_engine_if.sv
// Command and pixel-write bus of the rectangle fill engine.
// master = command source / framebuffer side, slave = engine side.
interface rect_fill_engine_if #(
    parameter int XW = 8,
    parameter int YW = 8,
    parameter int CW = 3
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [XW-1:0]      cmd_x0;
    logic [XW-1:0]      cmd_x1;
    logic [YW-1:0]      cmd_y0;
    logic [YW-1:0]      cmd_y1;
    logic               cmd_mode;
    logic [CW-1:0]      cmd_r;
    logic [CW-1:0]      cmd_g;
    logic [CW-1:0]      cmd_b;
    logic [XW-1:0]      X;
    logic [YW-1:0]      Y;
    logic [CW-1:0]      R;
    logic [CW-1:0]      G;
    logic [CW-1:0]      B;
    logic               wr_valid;
    logic               wr_ready;
    logic               busy;
    logic               done;
    logic [XW+YW-1:0]   pix_count;

    modport master (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_mode,
               cmd_r, cmd_g, cmd_b, wr_ready,
        input  cmd_ready, X, Y, R, G, B, wr_valid, busy, done, pix_count
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_mode,
               cmd_r, cmd_g, cmd_b, wr_ready,
        output cmd_ready, X, Y, R, G, B, wr_valid, busy, done, pix_count
    );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle fill/outline engine: one command in, one pixel write per beat out.
// Define RECT_CLIP_EN to clamp rectangles to the SCR_W x SCR_H framebuffer.
module rect_fill_engine #(
    parameter int XW    = 8,
    parameter int YW    = 8,
    parameter int CW    = 3,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic                CLK,
    input  logic                NRST,
    rect_fill_engine_if.slave   bus
);

`ifdef RECT_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif
    localparam logic [XW-1:0] XLIM = XW'(SCR_W - 1);
    localparam logic [YW-1:0] YLIM = YW'(SCR_H - 1);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    state_t             r_state, w_next;
    logic [XW-1:0]      r_x0, r_x1, r_xmin, r_xmax, r_x;
    logic [YW-1:0]      r_y0, r_y1, r_ymin, r_ymax, r_y;
    logic               r_mode;
    logic [CW-1:0]      r_cr, r_cg, r_cb, r_r, r_g, r_b;
    logic [XW+YW-1:0]   r_pix;

    logic               w_accept, w_beat, w_last, w_edge_row, w_skip;
    logic [XW-1:0]      w_xmin, w_xmax, w_x_nxt;
    logic [YW-1:0]      w_ymin, w_ymax, w_y_nxt;

    assign w_accept = bus.cmd_valid && (r_state == IDLE);
    assign w_beat   = (r_state == DRAW) && bus.wr_ready;

    // Corner ordering plus optional clamp; the skip case means nothing is on screen.
    always_comb begin
        w_xmin = (r_x0 < r_x1) ? r_x0 : r_x1;
        w_xmax = (r_x0 < r_x1) ? r_x1 : r_x0;
        w_ymin = (r_y0 < r_y1) ? r_y0 : r_y1;
        w_ymax = (r_y0 < r_y1) ? r_y1 : r_y0;
        w_skip = 1'b0;
        if (CLIP) begin
            if (w_xmax > XLIM) w_xmax = XLIM;
            if (w_ymax > YLIM) w_ymax = YLIM;
            w_skip = (w_xmin > XLIM) || (w_ymin > YLIM);
        end
    end

    assign w_last     = (r_x == r_xmax) && (r_y == r_ymax);
    assign w_edge_row = !r_mode || (r_y == r_ymin) || (r_y == r_ymax);

    // Interior outline rows jump straight from the left edge to the right edge.
    always_comb begin
        w_x_nxt = r_xmin;
        w_y_nxt = r_y + YW'(1);
        if (r_x < r_xmax) begin
            w_x_nxt = w_edge_row ? r_x + XW'(1) : r_xmax;
            w_y_nxt = r_y;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SETUP;
            SETUP:   w_next = w_skip ? DONE : DRAW;
            DRAW:    if (w_beat && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_x0 <= '0; r_x1 <= '0; r_y0 <= '0; r_y1 <= '0;
            r_mode <= 1'b0;
            r_cr <= '0; r_cg <= '0; r_cb <= '0;
            r_xmin <= '0; r_xmax <= '0; r_ymin <= '0; r_ymax <= '0;
            r_x <= '0; r_y <= '0;
            r_r <= '0; r_g <= '0; r_b <= '0;
            r_pix <= '0;
        end else begin
            if (w_accept) begin
                r_x0   <= bus.cmd_x0;
                r_x1   <= bus.cmd_x1;
                r_y0   <= bus.cmd_y0;
                r_y1   <= bus.cmd_y1;
                r_mode <= bus.cmd_mode;
                r_cr   <= bus.cmd_r;
                r_cg   <= bus.cmd_g;
                r_cb   <= bus.cmd_b;
                r_pix  <= '0;
            end
            if (r_state == SETUP) begin
                r_xmin <= w_xmin;
                r_xmax <= w_xmax;
                r_ymin <= w_ymin;
                r_ymax <= w_ymax;
                r_x    <= w_xmin;
                r_y    <= w_ymin;
                r_r    <= r_cr;
                r_g    <= r_cg;
                r_b    <= r_cb;
            end
            if (w_beat) begin
                r_pix <= r_pix + (XW+YW)'(1);
                if (!w_last) begin
                    r_x <= w_x_nxt;
                    r_y <= w_y_nxt;
                end
            end
        end
    end

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);
    assign bus.wr_valid  = (r_state == DRAW);
    assign bus.X         = r_x;
    assign bus.Y         = r_y;
    assign bus.R         = r_r;
    assign bus.G         = r_g;
    assign bus.B         = r_b;
    assign bus.pix_count = r_pix;

endmodule
